mips_fetch_unit: RTL

Parametrised instruction-fetch front end for the MIPS32 core, replacing the single-cycle PC register and next-PC mux with a fetch unit that tolerates variable-latency instruction memory. It owns the fetch PC and issues one outstanding request at a time on a req/ack memory port. Returned instructions are buffered in a DEPTH-entry prefetch queue and handed to decode over a valid/ready handshake. Branch and jump targets arrive from execute as a redirect, which flushes the queue and squashes any in-flight fetch.

---
 rtl/mips_fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/mips_fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch front end.
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

    // IDLE: nothing in flight; BUSY: live request in flight; KILL: squashed request in flight
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        KILL
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO; flush takes priority over push and pop.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// imem request at a time, buffers returned words and handles redirects.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_ir
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = XLEN + INSTR_W;

    fetch_state_t      state, state_n;
    logic [XLEN-1:0]   fpc, fpc_n;
    logic [XLEN-1:0]   req_addr, req_addr_n;
    logic [XLEN-1:0]   redirect_tgt;
    logic              q_push, push_c, q_pop;
    logic              q_full, q_empty;
    logic [QW-1:0]     q_head;
    logic [CW-1:0]     q_count;
    logic              unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect_valid),
        .din   ({imem_addr, imem_data}),
        .full  (q_full),
        .empty (q_empty),
        .head  (q_head),
        .count (q_count)
    );

    assign q_push   = push_c && !q_full;
    assign if_valid = !q_empty && !reset;
    assign q_pop    = if_valid && if_ready;
    assign if_pc    = if_valid ? q_head[QW-1:INSTR_W] : '0;
    assign if_ir    = if_valid ? q_head[INSTR_W-1:0]  : NOP_WORD;

    // State, fetch PC and in-flight address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_n;
            fpc      <= fpc_n;
            req_addr <= req_addr_n;
        end
    end

    // Request generation, next-state and PC update; redirect overrides push and fpc
    always_comb begin
        state_n    = state;
        fpc_n      = fpc;
        req_addr_n = req_addr;
        push_c     = 1'b0;
        imem_req   = 1'b0;
        imem_addr  = fpc;
        case (state)
            IDLE: begin
                imem_req  = (q_count < CW'(DEPTH)) && !reset;
                imem_addr = fpc;
                if (imem_req) begin
                    if (imem_ack) begin
                        push_c = 1'b1;
                        fpc_n  = fpc + XLEN'(4);
                    end else begin
                        req_addr_n = fpc;
                        state_n    = BUSY;
                    end
                end
            end
            BUSY: begin
                imem_req  = !reset;
                imem_addr = req_addr;
                if (imem_ack) begin
                    push_c  = 1'b1;
                    fpc_n   = req_addr + XLEN'(4);
                    state_n = IDLE;
                end
            end
            KILL: begin
                imem_req  = !reset;
                imem_addr = req_addr;
                if (imem_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A redirect leaves any in-flight request on the bus but marks it squashed
        if (redirect_valid) begin
            push_c = 1'b0;
            fpc_n  = redirect_tgt;
            if (imem_req && imem_ack) state_n = IDLE;
            else if (imem_req)        state_n = KILL;
        end
        if (reset) imem_addr = RESET_PC;
    end

endmodule
